// File: rtl/bus_pkg.sv
// Shared encodings and helpers for the bus arbiter/mux block.
package bus_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Index width with a one-bit floor so every channel count has a usable field.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/bus_arbiter_mux_if.sv
// Request/accept bundle between N producers, the arbiter/mux and one consumer.
interface bus_arbiter_mux_if
    import bus_pkg::*;
#(
    parameter int unsigned N = 4,
    parameter int unsigned W = 8
);
    localparam int unsigned CW = clog2(N);

    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [CW-1:0]  out_ch;
    logic           out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ch
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ch
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational channel selection: fixed priority or round-robin from ptr.
module rr_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned N = 4,
    localparam int unsigned CW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [CW-1:0] ptr,
    input  logic          mode,
    input  logic          enable,
    output logic [N-1:0]  grant,
    output logic [CW-1:0] idx
);

    always_comb begin
        int unsigned j;
        logic [CW-1:0] jc;
        logic found;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        jc    = '0;
        for (int unsigned k = 0; k < N; k++) begin
            j = k;
            // Rotate the scan start to ptr; ptr is always below N so one subtract wraps it.
            if (mode == MODE_RR) begin
                j = k + 32'(ptr);
                if (j >= N) begin
                    j = j - N;
                end
            end
            jc = CW'(j);
            if (enable && !found && req[jc]) begin
                found     = 1'b1;
                grant[jc] = 1'b1;
                idx       = jc;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_mux.sv
// N-to-1 arbitrated mux with a single registered output slot.
module bus_arbiter_mux
    import bus_pkg::*;
#(
    parameter int unsigned N = 4,
    parameter int unsigned W = 8,
    localparam int unsigned CW = clog2(N)
) (
    input logic              clk,
    input logic              rst,
    input logic              mode,
    bus_arbiter_mux_if.slave bus
);

    logic [N-1:0]  grant;
    logic [CW-1:0] grant_idx;
    logic          grant_any;
    logic          free;

    logic          out_valid_q;
    logic [W-1:0]  out_data_q;
    logic [CW-1:0] out_ch_q;
    logic [CW-1:0] ptr_q;

    // The slot frees up in the same cycle the consumer takes the held word.
    assign free = ~out_valid_q | bus.out_ready;

    rr_arbiter #(
        .N(N)
    ) u_arb (
        .req   (bus.in_valid),
        .ptr   (ptr_q),
        .mode  (mode),
        .enable(free & ~rst),
        .grant (grant),
        .idx   (grant_idx)
    );

    assign grant_any    = |grant;
    assign bus.in_ready = grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            ptr_q       <= '0;
        end else begin
            if (grant_any) begin
                out_valid_q <= 1'b1;
                out_data_q  <= bus.in_data[grant_idx*W +: W];
                out_ch_q    <= grant_idx;
                if (mode == MODE_RR) begin
                    ptr_q <= (grant_idx == CW'(N - 1)) ? '0 : grant_idx + CW'(1);
                end
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;

endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Randomised plus directed bench for bus_arbiter_mux with a scoreboard-backed reference model.
module tb_bus_arbiter_mux;

    localparam int unsigned N = 4;
    localparam int unsigned W = 8;

    typedef struct {
        int           ch;
        logic [W-1:0] data;
    } word_t;

    logic clk = 1'b0;
    logic rst;
    logic mode;
    logic mode3;

    int checks = 0;
    int errors = 0;

    // Reference model state: one output slot, a rotating start pointer.
    bit          m_valid;
    int          m_ptr;
    int          pend_g;
    logic        pend_mode;
    logic        pend_ready;
    word_t       sb[$];

    bus_arbiter_mux_if #(.N(N), .W(W)) bus ();
    bus_arbiter_mux_if #(.N(3), .W(W)) bus3 ();

    bus_arbiter_mux #(.N(N), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .mode(mode),
        .bus (bus)
    );

    bus_arbiter_mux #(.N(3), .W(W)) dut3 (
        .clk (clk),
        .rst (rst),
        .mode(mode3),
        .bus (bus3)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // First requesting channel met when walking the channels in order from 'start'.
    function automatic int pick(input logic [N-1:0] v, input int start);
        for (int k = 0; k < N; k++) begin
            int c;
            c = (start + k) % N;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [N*W-1:0] rand_data();
        logic [N*W-1:0] d;
        for (int i = 0; i < N; i++) begin
            d[i*W +: W] = W'($urandom);
        end
        return d;
    endfunction

    // One clock cycle: retire the previous cycle in the model, drive new inputs, predict grant.
    task automatic step(input logic m, input logic [N-1:0] v, input logic [N*W-1:0] d,
                        input logic rdy);
        int g;
        @(posedge clk);
        #2;
        if (pend_g >= 0) begin
            m_valid = 1'b1;
            if (pend_mode) m_ptr = (pend_g + 1) % N;
        end else if (m_valid && pend_ready) begin
            m_valid = 1'b0;
        end
        mode          = m;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = rdy;
        #1;
        if (m_valid && !rdy) g = -1;
        else                 g = pick(v, m ? m_ptr : 0);
        check("in_ready", 32'(bus.in_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
        if (g >= 0) sb.push_back('{ch: g, data: d[g*W +: W]});
        pend_g     = g;
        pend_mode  = m;
        pend_ready = rdy;
    endtask

    task automatic reset_now();
        rst           = 1'b1;
        bus.in_valid  = '0;
        bus3.in_valid = '0;
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_out_ch", 32'(bus.out_ch), 32'd0);
        check("rst_ptr", 32'(dut.ptr_q), 32'd0);
        sb.delete();
        m_valid    = 1'b0;
        m_ptr      = 0;
        pend_g     = -1;
        pend_ready = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    // Monitor: compares every output transfer against the oldest scoreboard entry.
    always @(negedge clk) begin
        if (!rst) begin
            check("out_valid", 32'(bus.out_valid), 32'(m_valid));
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow: output transfer ch %0d data %0h with no expected word",
                             bus.out_ch, bus.out_data);
                end else begin
                    word_t w;
                    w = sb.pop_front();
                    check("out_ch", 32'(bus.out_ch), 32'(w.ch));
                    check("out_data", 32'(bus.out_data), 32'(w.data));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [N*W-1:0] d;
        logic           m;
        rst            = 1'b1;
        mode           = 1'b0;
        mode3          = 1'b1;
        bus.in_valid   = '1;
        bus.in_data    = '1;
        bus.out_ready  = 1'b1;
        bus3.in_valid  = '1;
        bus3.in_data   = '1;
        bus3.out_ready = 1'b1;
        m_valid        = 1'b0;
        m_ptr          = 0;
        pend_g         = -1;
        pend_mode      = 1'b0;
        pend_ready     = 1'b0;

        // Reset holds everything quiet even with requests pending and across edges.
        #3;
        check("por_in_ready", 32'(bus.in_ready), 32'd0);
        check("por_out_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("por_in_ready_edge", 32'(bus.in_ready), 32'd0);
        check("por_in_ready3", 32'(bus3.in_ready), 32'd0);
        check("por_out_data", 32'(bus.out_data), 32'd0);
        check("por_ptr", 32'(dut.ptr_q), 32'd0);
        @(posedge clk);
        #2;
        rst           = 1'b0;
        bus.in_valid  = '0;
        bus3.in_valid = '0;

        // Fixed priority picks the lowest requester, then idle drain keeps the last word.
        d = rand_data();
        step(1'b0, 4'b1010, d, 1'b1);
        check("fp_in_ready", 32'(bus.in_ready), 32'b0010);
        step(1'b0, 4'b0000, rand_data(), 1'b1);
        check("fp_out_ch", 32'(bus.out_ch), 32'd1);
        check("fp_out_data", 32'(bus.out_data), 32'(d[15:8]));
        step(1'b0, 4'b0000, rand_data(), 1'b1);
        check("drain_valid", 32'(bus.out_valid), 32'd0);
        check("drain_data", 32'(bus.out_data), 32'(d[15:8]));

        // Reset while a word is held.
        d = rand_data();
        d[7:0] = 8'hA5;
        step(1'b0, 4'b0001, d, 1'b0);
        step(1'b0, 4'b0000, rand_data(), 1'b0);
        check("held_valid", 32'(bus.out_valid), 32'd1);
        check("held_data", 32'(bus.out_data), 32'h A5);
        reset_now();

        // Round-robin fairness with every channel requesting.
        for (int k = 1; k <= 9; k++) begin
            step(1'b1, 4'b1111, rand_data(), 1'b1);
            if (k >= 2) check("rr_seq", 32'(bus.out_ch), 32'((k - 2) % 4));
        end

        // Backpressure: held word stays put, then the next channel is granted back-to-back.
        reset_now();
        d = rand_data();
        d[7:0] = 8'h3C;
        step(1'b1, 4'b1111, d, 1'b1);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 4'b1111, rand_data(), 1'b0);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check("bp_out_data", 32'(bus.out_data), 32'h3C);
        end
        d = rand_data();
        step(1'b1, 4'b1111, d, 1'b1);
        check("bp_resume_grant", 32'(bus.in_ready), 32'b0010);
        step(1'b1, 4'b0000, rand_data(), 1'b1);
        check("bp_resume_ch", 32'(bus.out_ch), 32'd1);
        check("bp_resume_data", 32'(bus.out_data), 32'(d[15:8]));

        // Three-channel instance: round-robin must wrap from 2 to 0.
        reset_now();
        mode3          = 1'b1;
        bus3.in_valid  = 3'b101;
        bus3.in_data   = {8'h33, 8'h22, 8'h11};
        bus3.out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step(1'b0, 4'b0000, rand_data(), 1'b1);
            check("n3_ch", 32'(bus3.out_ch), (k % 2 == 1) ? 32'd0 : 32'd2);
            check("n3_data", 32'(bus3.out_data), (k % 2 == 1) ? 32'h11 : 32'h33);
            check("n3_ptr", 32'(dut3.ptr_q), (k % 2 == 1) ? 32'd1 : 32'd0);
        end
        bus3.in_valid = '0;

        // Random traffic with occasional mode flips and resets.
        m = 1'b1;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 15) == 0) m = ~m;
            if ($urandom_range(0, 99) == 0) reset_now();
            step(m, N'($urandom), rand_data(), $urandom_range(0, 3) != 0);
        end

        step(m, 4'b0000, rand_data(), 1'b1);
        step(m, 4'b0000, rand_data(), 1'b1);
        step(m, 4'b0000, rand_data(), 1'b1);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_arbiter_mux.md
BUS_ARBITER_MUX -- requirements
Module: bus_arbiter_mux

Interface
REQ-001 Parameter N, default 4: number of input channels, legal range 2..16.
REQ-002 Parameter W, default 8: data width per channel, at least 1.
REQ-003 Derived constant CW = max(1, clog2(N)): channel-index width.
REQ-004 Clock  in  1  single clock; all state changes on its rising edge.
REQ-005 Reset  in  1  asynchronous, active-high reset.
REQ-006 mode  in  1  arbitration mode: 0 = fixed priority (lowest index wins), 1 = round-robin.
REQ-007 in_valid  in  N  per-channel request; bit i belongs to channel i.
REQ-008 in_data  in  N*W  channel i data occupies bits [i*W+W-1 : i*W].
REQ-009 in_ready  out  N  per-channel accept, combinational, at most one bit set (one-hot or zero).
REQ-010 out_valid  out  1  output register holds a word.
REQ-011 out_data  out  W  registered word.
REQ-012 out_ch  out  CW  registered index of the channel that supplied out_data.
REQ-013 out_ready  in  1  downstream accepts the word this cycle.

Function
REQ-014 Transfer rules: an input transfer occurs on a cycle with in_valid[i] & in_ready[i]; an output transfer occurs on a cycle with out_valid & out_ready.
REQ-015 Output slot free: free = ~out_valid | out_ready, so the block sustains one word per cycle when out_ready stays high.
REQ-016 Grant condition: a grant is issued only when free = 1 and at least one in_valid bit is set; otherwise in_ready = 0.
REQ-017 Grant selection, mode 0: grant the lowest set index of in_valid.
REQ-018 Grant selection, mode 1: grant the first set index found by scanning upward, with wrap, from the pointer ptr.
REQ-019 Grant output: in_ready[g] = 1 for the granted channel g only, in the same cycle (no registered grant).
REQ-020 Capture: on the edge after a grant, out_data <= in_data[g], out_ch <= g, out_valid <= 1; latency from input transfer to out_valid is 1 cycle.
REQ-021 Drain: if an output transfer occurs and no grant is issued, out_valid <= 0 on that edge; out_data and out_ch hold their values.
REQ-022 Stall: while out_valid = 1 and out_ready = 0, out_data and out_ch are stable and all in_ready bits are 0.
REQ-023 Pointer update: ptr is CW bits wide and is updated only on a grant in mode 1, to (g+1) mod N; the wrap from N-1 goes to 0 and applies for any N, not only powers of two.
REQ-024 Pointer hold: ptr holds while mode = 0; a mode change affects the next grant decision only and no in-flight word is altered.
REQ-025 Sampling: a channel may drop in_valid without having been granted; the block imposes no stickiness.
REQ-026 Ignored inputs: in_data of non-granted channels is ignored.
REQ-027 Fairness: in mode 1 with all N channels continuously valid and out_ready = 1, grants cycle 0,1,...,N-1,0 with no repeats.

Reset
REQ-028 While Reset = 1: out_valid = 0, out_data = 0, out_ch = 0, ptr = 0, in_ready = 0, all regardless of Clock.
REQ-029 Reset mid-operation discards any held word; the first grant after release follows REQ-017 or REQ-018 with ptr = 0.
REQ-030 Reset deassertion is synchronised externally; no synchronizer is inside the block.

Structure
REQ-031 Shared package bus_pkg holds the mode encodings MODE_FIXED = 0 and MODE_RR = 1, and the clog2 helper function.
REQ-032 Sub-module rr_arbiter (parameter N; inputs req, ptr, mode, enable; output one-hot grant plus encoded index) holds all selection logic.
REQ-033 The top level holds the output register, the pointer register and the data mux.
REQ-034 The data mux is an indexed part-select on in_data; it uses no instantiated gate-level cells.

Verification
REQ-035 Reset with held data: assert Reset while out_valid = 1 and out_data = 8'hA5 -> out_valid = 0, out_data = 0 and ptr = 0 immediately, before the next clock edge.
REQ-036 Fixed priority: mode = 0, in_valid = 4'b1010, out_ready = 1 -> in_ready = 4'b0010, next cycle out_ch = 1 and out_data = channel-1 data.
REQ-037 Round-robin: mode = 1, in_valid = 4'b1111 held, out_ready = 1 for 8 cycles -> out_ch sequence is 0,1,2,3,0,1,2,3.
REQ-038 Backpressure: out_valid = 1, out_data = 8'h3C, out_ready = 0 for 5 cycles with all channels valid -> in_ready = 0 and out_data = 8'h3C throughout; the first cycle with out_ready = 1 grants the next channel with back-to-back capture.
REQ-039 Non-power-of-two wrap: N = 3, mode = 1, in_valid = 3'b101 continuous -> out_ch alternates 0,2,0,2; ptr never reaches 3.
REQ-040 Idle drain: single word captured, in_valid = 0, out_ready = 1 -> out_valid falls one cycle after the output transfer and out_data keeps its last value.
